corefifo_rd_ptr_ctrl: RTL and testbench



---
 rtl/corefifo_rd_ptr_ctrl_pkg.sv | 14 +
 rtl/corefifo_grayToBinConv.sv | 17 +
 rtl/corefifo_rd_ptr_ctrl.sv | 91 +++++++++
 tb/tb_corefifo_rd_ptr_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/corefifo_rd_ptr_ctrl_pkg.sv
// Shared constants and helpers for the FIFO read-side pointer logic.
// The defaults describe the standard 8-deep configuration.
package corefifo_rd_ptr_ctrl_pkg;

    localparam int unsigned ADDRWIDTH_DEF = 3;
    localparam int unsigned PTRW          = ADDRWIDTH_DEF + 1;
    localparam int unsigned DEPTH         = 2 ** ADDRWIDTH_DEF;

    // Callers size-cast the result down to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/corefifo_grayToBinConv.sv
// Combinational Gray-to-binary converter for ADDRWIDTH+1 bit FIFO pointers.
module corefifo_grayToBinConv #(
    parameter int unsigned ADDRWIDTH = 3
) (
    input  logic [ADDRWIDTH:0] gray,
    output logic [ADDRWIDTH:0] bin
);

    always_comb begin
        bin = '0;
        bin[ADDRWIDTH] = gray[ADDRWIDTH];
        for (int i = int'(ADDRWIDTH) - 1; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/corefifo_rd_ptr_ctrl.sv
// Read-domain pointer/flag controller for the async FIFO: synchronises the Gray
// write pointer, keeps the read pointers and produces empty/aempty/rdcnt/underflow.
module corefifo_rd_ptr_ctrl
    import corefifo_rd_ptr_ctrl_pkg::*;
#(
    parameter int unsigned ADDRWIDTH   = ADDRWIDTH_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDRWIDTH:0]   wptr_gray_async,
    input  logic                 re,
    output logic                 mem_rd_en,
    output logic [ADDRWIDTH-1:0] raddr,
    output logic [ADDRWIDTH:0]   rptr_gray,
    output logic                 empty,
    output logic                 aempty,
    output logic [ADDRWIDTH:0]   rdcnt,
    output logic                 underflow
);

    localparam int unsigned PTR_W = ADDRWIDTH + 1;

    logic             rd_ok;
    logic [PTR_W-1:0] rptr_bin_q, rptr_bin_d;
    logic [PTR_W-1:0] rptr_gray_q, rptr_gray_d;
    logic [PTR_W-1:0] rdcnt_q, cnt_d;
    logic             empty_q, aempty_q, underflow_q;
    logic [PTR_W-1:0] wptr_gray_sync, wptr_bin;

    // Plain flop chain, no logic between stages, so it is safe for CDC.
    for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
        logic [PTR_W-1:0] q;
        if (s == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (reset) q <= '0;
                else       q <= wptr_gray_async;
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (reset) q <= '0;
                else       q <= g_sync[s-1].q;
            end
        end
    end

    assign wptr_gray_sync = g_sync[SYNC_STAGES-1].q;

    corefifo_grayToBinConv #(
        .ADDRWIDTH (ADDRWIDTH)
    ) u_g2b (
        .gray (wptr_gray_sync),
        .bin  (wptr_bin)
    );

    always_comb begin
        rd_ok       = re & ~empty_q;
        rptr_bin_d  = rptr_bin_q + {{(PTR_W-1){1'b0}}, rd_ok};
        rptr_gray_d = PTR_W'(bin2gray(32'(rptr_bin_d)));
        // Flags follow next-state pointers so an accepted read is visible immediately.
        cnt_d       = wptr_bin - rptr_bin_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_bin_q  <= '0;
            rptr_gray_q <= '0;
            rdcnt_q     <= '0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rptr_bin_q  <= rptr_bin_d;
            rptr_gray_q <= rptr_gray_d;
            rdcnt_q     <= cnt_d;
            empty_q     <= (cnt_d == '0);
            aempty_q    <= (cnt_d <= PTR_W'(AE_THRESH));
            underflow_q <= re & empty_q;
        end
    end

    assign mem_rd_en = rd_ok;
    assign raddr     = rptr_bin_q[ADDRWIDTH-1:0];
    assign rptr_gray = rptr_gray_q;
    assign empty     = empty_q;
    assign aempty    = aempty_q;
    assign rdcnt     = rdcnt_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_corefifo_rd_ptr_ctrl.sv
// Directed self-checking bench for corefifo_rd_ptr_ctrl (ADDRWIDTH=3, 2 sync stages).
module tb_corefifo_rd_ptr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] wptr_gray_async;
    logic       re;
    logic       mem_rd_en;
    logic [2:0] raddr;
    logic [3:0] rptr_gray;
    logic       empty;
    logic       aempty;
    logic [3:0] rdcnt;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    // Standard 4-bit reflected Gray code, written out by hand.
    logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    always #5 clk = ~clk;

    corefifo_rd_ptr_ctrl #(
        .ADDRWIDTH   (3),
        .SYNC_STAGES (2),
        .AE_THRESH   (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wptr_gray_async (wptr_gray_async),
        .re              (re),
        .mem_rd_en       (mem_rd_en),
        .raddr           (raddr),
        .rptr_gray       (rptr_gray),
        .empty           (empty),
        .aempty          (aempty),
        .rdcnt           (rdcnt),
        .underflow       (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ones(input logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    initial begin
        int rp;
        int wp;
        logic [3:0] prev_g;

        // Reset held two clocks with a read request pending.
        reset = 1'b1;
        re = 1'b1;
        wptr_gray_async = 4'b0000;
        step();
        step();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_aempty", 32'(aempty), 32'd1);
        check("rst_rdcnt", 32'(rdcnt), 32'd0);
        check("rst_rptr_gray", 32'(rptr_gray), 32'd0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        reset = 1'b0;
        re = 1'b0;
        step();

        // Sync latency: pointer 0 -> 1 is seen on the third edge.
        wptr_gray_async = 4'b0001;
        step();
        step();
        check("lat_empty_2clk", 32'(empty), 32'd1);
        step();
        check("lat_empty_3clk", 32'(empty), 32'd0);
        check("lat_rdcnt", 32'(rdcnt), 32'd1);
        check("lat_aempty", 32'(aempty), 32'd1);

        // Drain four words, then one read while empty.
        wptr_gray_async = 4'b0110;
        step();
        step();
        step();
        check("drain_rdcnt4", 32'(rdcnt), 32'd4);
        check("drain_aempty4", 32'(aempty), 32'd0);
        re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_rd_en", 32'(mem_rd_en), 32'd1);
            check("drain_raddr", 32'(raddr), 32'(i));
            step();
            check("drain_rdcnt", 32'(rdcnt), 32'(3 - i));
            check("drain_aempty", 32'(aempty), (i >= 1) ? 32'd1 : 32'd0);
            check("drain_empty", 32'(empty), (i == 3) ? 32'd1 : 32'd0);
        end
        check("uf_rd_en", 32'(mem_rd_en), 32'd0);
        step();
        check("uf_pulse", 32'(underflow), 32'd1);
        check("uf_rdcnt", 32'(rdcnt), 32'd0);
        check("uf_rptr_gray", 32'(rptr_gray), 32'(gtab[4]));
        re = 1'b0;
        step();
        check("uf_clear", 32'(underflow), 32'd0);

        // Wrap: 16 single-word write/read rounds starting from pointer 4.
        rp = 4;
        wp = 4;
        for (int i = 0; i < 16; i++) begin
            wp = (wp + 1) % 16;
            wptr_gray_async = gtab[wp];
            step();
            step();
            step();
            check("wrap_rdcnt1", 32'(rdcnt), 32'd1);
            re = 1'b1;
            #1;
            check("wrap_rd_en", 32'(mem_rd_en), 32'd1);
            check("wrap_raddr", 32'(raddr), 32'(rp % 8));
            prev_g = rptr_gray;
            step();
            re = 1'b0;
            rp = (rp + 1) % 16;
            check("wrap_gray", 32'(rptr_gray), 32'(gtab[rp]));
            check("wrap_one_bit", 32'(ones(prev_g ^ rptr_gray)), 32'd1);
            check("wrap_empty", 32'(empty), 32'd1);
        end

        // Simultaneous read and pointer arrival with one word stored.
        wptr_gray_async = gtab[5];
        step();
        step();
        step();
        check("sim_rdcnt_pre", 32'(rdcnt), 32'd1);
        wptr_gray_async = gtab[6];
        step();
        step();
        check("sim_rdcnt_wait", 32'(rdcnt), 32'd1);
        re = 1'b1;
        #1;
        check("sim_rd_en", 32'(mem_rd_en), 32'd1);
        step();
        re = 1'b0;
        check("sim_rdcnt", 32'(rdcnt), 32'd1);
        check("sim_empty", 32'(empty), 32'd0);
        check("sim_gray", 32'(rptr_gray), 32'(gtab[5]));

        // Reset mid-operation with five words stored and a read pending.
        wptr_gray_async = gtab[10];
        step();
        step();
        step();
        check("mid_rdcnt5", 32'(rdcnt), 32'd5);
        re = 1'b1;
        reset = 1'b1;
        step();
        check("mid_rst_rdcnt", 32'(rdcnt), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_aempty", 32'(aempty), 32'd1);
        check("mid_rst_gray", 32'(rptr_gray), 32'd0);
        check("mid_rst_uf", 32'(underflow), 32'd0);
        reset = 1'b0;
        re = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
